alarm_demux8: RTL and testbench

Receive-side counterpart to the 8-input alarm selector. It takes the single time-multiplexed ALARM line, which the scanner drives one zone per slot with a frame-start SYNC, and rebuilds the eight per-zone alarm bits. It tracks the slot number in step with the scanner, checks framing, and publishes a complete 8-bit zone vector once per frame. Optionally it also keeps a per-zone sticky (latched) alarm register for the operator panel.

---
 rtl/alarm_demux8.sv | 137 +++++++++++++
 tb/tb_alarm_demux8.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_demux8.sv
// alarm_demux8: receive side of the 8-zone time-multiplexed alarm line.
// Tracks the scanner's slot number, checks framing against SYNC and publishes
// a full 8-bit zone vector once per frame.
// Optional feature: define ALARM_DEMUX_STICKY_EN to build the per-zone sticky
// alarm register (cleared by ack). Without it, sticky is tied to 0.
module alarm_demux8 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       sync,
  input  logic       alarm,
  input  logic [7:0] ack,
  output logic [2:0] sel,
  output logic [7:0] zone,
  output logic       frame_valid,
  output logic       sync_err,
  output logic       locked,
  output logic [7:0] sticky
);

  typedef enum logic [0:0] {StHunt, StRun} state_e;

  state_e     state_q;
  logic [6:0] shadow_q;
  logic [2:0] sel_q;
  logic [7:0] zone_q;
  logic       frame_valid_q;
  logic       sync_err_q;
  logic       locked_q;

  // Frame commit: slot 7 sampled in RUN without an early SYNC.
  logic       commit;
  logic [7:0] new_zone;

  // Decode the commit condition and the vector it would publish.
  always_comb begin
    commit   = en && (state_q == StRun) && (sel_q == 3'd7) && !sync;
    new_zone = {alarm, shadow_q};
  end

  // Framing FSM with capture shadow and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StHunt;
      shadow_q      <= '0;
      sel_q         <= '0;
      zone_q        <= '0;
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      locked_q      <= 1'b0;
    end else begin
      // Pulses are single-cycle by default.
      frame_valid_q <= 1'b0;
      sync_err_q    <= 1'b0;
      if (en) begin
        unique case (state_q)
          StHunt: begin
            // Non-SYNC samples are silently dropped while hunting.
            if (sync) begin
              shadow_q[0] <= alarm;
              sel_q       <= 3'd1;
              state_q     <= StRun;
              locked_q    <= 1'b1;
            end
          end
          StRun: begin
            if (sel_q == 3'd0) begin
              if (sync) begin
                shadow_q[0] <= alarm;
                sel_q       <= 3'd1;
              end else begin
                // Missing SYNC at the frame boundary: lose lock, keep zone.
                sync_err_q <= 1'b1;
                state_q    <= StHunt;
                locked_q   <= 1'b0;
              end
            end else if (sync) begin
              // Early SYNC: drop the partial frame and restart at slot 0.
              sync_err_q  <= 1'b1;
              shadow_q[0] <= alarm;
              sel_q       <= 3'd1;
            end else if (sel_q == 3'd7) begin
              // Slot 7 goes straight into zone; shadow only holds 0..6.
              zone_q        <= new_zone;
              frame_valid_q <= 1'b1;
              sel_q         <= 3'd0;
            end else begin
              shadow_q[sel_q] <= alarm;
              sel_q           <= sel_q + 3'd1;
            end
          end
          default: begin
            state_q  <= StHunt;
            locked_q <= 1'b0;
            sel_q    <= '0;
          end
        endcase
      end
    end
  end

`ifdef ALARM_DEMUX_STICKY_EN
  logic [7:0] sticky_q;
  logic [7:0] sticky_d;

  // New alarms are OR-ed in after the clear so a same-cycle set wins over ack.
  always_comb begin
    sticky_d = sticky_q & ~ack;
    if (commit) begin
      sticky_d = sticky_d | new_zone;
    end
  end

  // Sticky register update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sticky_q <= '0;
    end else begin
      sticky_q <= sticky_d;
    end
  end

  assign sticky = sticky_q;
`else
  // Feature absent: ack and the commit decode have no load.
  logic unused_sticky_inputs;
  assign unused_sticky_inputs = ^{ack, commit, new_zone};
  assign sticky = '0;
`endif

  assign sel         = sel_q;
  assign zone        = zone_q;
  assign frame_valid = frame_valid_q;
  assign sync_err    = sync_err_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_alarm_demux8.sv
// tb_alarm_demux8: directed scenarios plus randomized traffic, checked each
// cycle against a frame-level behavioural model of the alarm demux.
module tb_alarm_demux8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       sync = 1'b0;
  logic       alarm = 1'b0;
  logic [7:0] ack = 8'h00;
  logic [2:0] sel;
  logic [7:0] zone;
  logic       frame_valid;
  logic       sync_err;
  logic       locked;
  logic [7:0] sticky;

  int checks = 0;
  int errors = 0;
  int fv_count = 0;

  alarm_demux8 dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .sync        (sync),
    .alarm       (alarm),
    .ack         (ack),
    .sel         (sel),
    .zone        (zone),
    .frame_valid (frame_valid),
    .sync_err    (sync_err),
    .locked      (locked),
    .sticky      (sticky)
  );

  always #5 clk = ~clk;

  // Model: count of bits gathered in the current frame plus the bits themselves.
  logic       m_run = 1'b0;
  int         m_n = 0;
  logic [7:0] m_bits = '0;
  logic [7:0] m_zone = '0;
  logic       m_fv = 1'b0;
  logic       m_err = 1'b0;
  logic [7:0] m_sticky = '0;

  always @(posedge clk or negedge rst_n) begin : model
    logic       run;
    int         n;
    logic [7:0] bits;
    logic [7:0] z;
    logic       fv;
    logic       err;
    logic [7:0] st;
    if (!rst_n) begin
      m_run <= 1'b0; m_n <= 0; m_bits <= '0; m_zone <= '0;
      m_fv <= 1'b0; m_err <= 1'b0; m_sticky <= '0;
    end else begin
      run = m_run; n = m_n; bits = m_bits; z = m_zone; fv = 1'b0; err = 1'b0;
      if (en) begin
        if (!run) begin
          if (sync) begin run = 1'b1; bits = '0; bits[0] = alarm; n = 1; end
        end else if (sync) begin
          err = (n != 0); bits = '0; bits[0] = alarm; n = 1;
        end else if (n == 0) begin
          err = 1'b1; run = 1'b0;
        end else begin
          bits[n] = alarm;
          n = n + 1;
          if (n == 8) begin z = bits; fv = 1'b1; n = 0; end
        end
      end
`ifdef ALARM_DEMUX_STICKY_EN
      st = (m_sticky & ~ack) | (fv ? z : 8'h00);
`else
      st = 8'h00;
`endif
      m_run <= run; m_n <= n; m_bits <= bits; m_zone <= z;
      m_fv <= fv; m_err <= err; m_sticky <= st;
    end
  end

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every output against the model away from the active edge.
  always @(negedge clk) begin
    check("sel", {5'd0, sel}, m_run ? 8'(m_n % 8) : 8'h00);
    check("zone", zone, m_zone);
    check("frame_valid", {7'd0, frame_valid}, {7'd0, m_fv});
    check("sync_err", {7'd0, sync_err}, {7'd0, m_err});
    check("locked", {7'd0, locked}, {7'd0, m_run});
    check("sticky", sticky, m_sticky);
    if (frame_valid === 1'b1) fv_count = fv_count + 1;
  end

  // One clock of stimulus; returns 1 time unit after the sampling edge.
  task automatic step(input logic e, input logic s, input logic a);
    en = e; sync = s; alarm = a;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] v, input bit gap);
    for (int i = 0; i < 8; i++) begin
      step(1'b1, i == 0, v[i]);
      if (gap && i != 7) begin
        step(1'b0, 1'b0, 1'b0);
        check("gap_sel_hold", {5'd0, sel}, 8'(i + 1));
      end
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int f0;
    int cnt;
    logic s;
    #12 rst_n = 1'b1;
    #1 check("reset_zone", zone, 8'h00);
    check("reset_locked", {7'd0, locked}, 8'h00);
    @(posedge clk); #1;

    // Clean frame 1,0,1,1,0,0,0,1 -> 8'h8D.
    f0 = fv_count;
    send_frame(8'h8D, 1'b0);
    check("clean_zone", zone, 8'h8D);
    check("clean_locked", {7'd0, locked}, 8'h01);
    step(1'b0, 1'b0, 1'b0);
    check("clean_fv_once", 8'(fv_count - f0), 8'h01);

    // Same frame with idle slots in between.
    rst_n = 1'b0; #2 rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);
    f0 = fv_count;
    send_frame(8'h8D, 1'b1);
    check("gap_zone", zone, 8'h8D);
    step(1'b0, 1'b0, 1'b0);
    check("gap_fv_once", 8'(fv_count - f0), 8'h01);

    // Early SYNC at slot 4 with partial frame A pending.
    for (int i = 0; i < 4; i++) step(1'b1, i == 0, 1'b1);
    check("early_sel", {5'd0, sel}, 8'h04);
    f0 = fv_count;
    step(1'b1, 1'b1, 1'b1);
    check("early_err", {7'd0, sync_err}, 8'h01);
    check("early_zone_held", zone, 8'h8D);
    for (int i = 1; i < 8; i++) step(1'b1, 1'b0, 1'b1);
    check("early_zone_ff", zone, 8'hFF);
    step(1'b0, 1'b0, 1'b0);
    check("early_fv_once", 8'(fv_count - f0), 8'h01);

    // Missing SYNC after a good frame.
    send_frame(8'h5A, 1'b0);
    step(1'b1, 1'b0, 1'b1);
    check("miss_err", {7'd0, sync_err}, 8'h01);
    check("miss_unlocked", {7'd0, locked}, 8'h00);
    check("miss_zone_held", zone, 8'h5A);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 1'b1);
    check("miss_hunt_sel", {5'd0, sel}, 8'h00);
    send_frame(8'h33, 1'b0);
    check("relock_zone", zone, 8'h33);

    // Sticky behaviour.
    ack = 8'hFF; step(1'b0, 1'b0, 1'b0); ack = 8'h00;
    send_frame(8'h04, 1'b0);
    send_frame(8'h00, 1'b0);
`ifdef ALARM_DEMUX_STICKY_EN
    check("sticky_latch", sticky, 8'h04);
    ack = 8'h04;
    send_frame(8'h04, 1'b0);
    check("sticky_set_wins", {7'd0, sticky[2]}, 8'h01);
    step(1'b0, 1'b0, 1'b0);
    ack = 8'h00;
    check("sticky_ack_clear", sticky, 8'h00);
`else
    check("sticky_off", sticky, 8'h00);
`endif

    // Mid-frame asynchronous reset at slot 5.
    for (int i = 0; i < 5; i++) step(1'b1, i == 0, 1'b1);
    check("pre_reset_sel", {5'd0, sel}, 8'h05);
    #2 rst_n = 1'b0;
    #1 check("rst_zone", zone, 8'h00);
    check("rst_sel", {5'd0, sel}, 8'h00);
    check("rst_locked", {7'd0, locked}, 8'h00);
    @(posedge clk); #3 rst_n = 1'b1;
    @(posedge clk); #1;
    send_frame(8'h3C, 1'b0);
    check("post_reset_zone", zone, 8'h3C);

    // Random traffic, mostly well framed with occasional faults.
    cnt = 0;
    for (int c = 0; c < 3000; c++) begin
      ack = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00;
      if ($urandom_range(0, 9) < 7) begin
        if (cnt == 0) s = ($urandom_range(0, 19) != 0);
        else s = ($urandom_range(0, 39) == 0);
        cnt = s ? 1 : (cnt + 1) % 8;
        step(1'b1, s, 1'($urandom));
      end else begin
        step(1'b0, 1'($urandom), 1'($urandom));
      end
    end
    ack = 8'h00;
    step(1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
